// File: rtl/aes_blok_paketleyici.sv
// Packs a byte stream into padded 128-bit blocks, queues them in a small FIFO
// and hands each block to the AES engine with a one-cycle start pulse.
module aes_blok_paketleyici #(
  parameter int FIFO_DERINLIK = 2,
  parameter int DOLGU_MODU    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     g_bayt,
  input  logic                           g_bayt_gecerli,
  input  logic                           g_bayt_son,
  output logic                           g_bayt_hazir,
  input  logic                           hazir,
  output logic [127:0]                   blok,
  output logic                           g_gecerli,
  output logic                           fifo_bos,
  output logic                           fifo_dolu,
  output logic [$clog2(FIFO_DERINLIK):0] seviye
);
  localparam int          AW       = $clog2(FIFO_DERINLIK);
  localparam logic [AW:0] DERINLIK = (AW+1)'(FIFO_DERINLIK);
  localparam logic [AW:0] BIR      = (AW+1)'(1);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    GONDER = 2'd1,
    BEKLE  = 2'd2
  } durum_t;

  logic [3:0]   k_q, k_d;
  logic [127:0] pack_q, pack_d;
  logic [127:0] push_word;
  logic [7:0]   pad_bayt;
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [127:0] mem [FIFO_DERINLIK];
  logic [127:0] blok_q, blok_d;
  logic         g_gecerli_q, g_gecerli_d;
  durum_t       durum_q, durum_d;
  logic         kabul, push, pop;
  logic [AW:0]  seviye_w;

  assign seviye_w     = wr_q - rd_q;
  assign fifo_bos     = (seviye_w == '0);
  assign fifo_dolu    = (seviye_w == DERINLIK);
  assign g_bayt_hazir = !fifo_dolu;
  assign seviye       = seviye_w;
  assign blok         = blok_q;
  assign g_gecerli    = g_gecerli_q;

  assign kabul    = g_bayt_gecerli & g_bayt_hazir;
  assign push     = kabul & (g_bayt_son | (k_q == 4'd15));
  assign pad_bayt = (DOLGU_MODU == 1) ? {4'h0, 4'd15 - k_q} : 8'h00;

  // Byte slot gi: already-packed byte, the incoming byte, or padding beyond it.
  for (genvar gi = 0; gi < 16; gi++) begin : g_yerlesim
    assign push_word[127-8*gi -: 8] = (4'(gi) < k_q)  ? pack_q[127-8*gi -: 8] :
                                      (4'(gi) == k_q) ? g_bayt : pad_bayt;
  end

  always_comb begin
    k_d    = k_q;
    pack_d = pack_q;
    wr_d   = wr_q;
    if (kabul) begin
      pack_d = push_word;
      k_d    = push ? 4'd0 : k_q + 4'd1;
    end
    if (push) begin
      wr_d = wr_q + BIR;
    end
  end

  always_comb begin
    durum_d     = durum_q;
    g_gecerli_d = 1'b0;
    blok_d      = blok_q;
    pop         = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (!fifo_bos && hazir) begin
          blok_d      = mem[rd_q[AW-1:0]];
          pop         = 1'b1;
          g_gecerli_d = 1'b1;
          durum_d     = GONDER;
        end
      end
      GONDER: durum_d = BEKLE;
      // Re-arm only after hazir falls, so a long-high hazir issues once.
      BEKLE: if (!hazir) durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
    rd_d = pop ? rd_q + BIR : rd_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q[AW-1:0]] <= push_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q         <= 4'd0;
      pack_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      blok_q      <= '0;
      g_gecerli_q <= 1'b0;
      durum_q     <= BOSTA;
    end else begin
      k_q         <= k_d;
      pack_q      <= pack_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      blok_q      <= blok_d;
      g_gecerli_q <= g_gecerli_d;
      durum_q     <= durum_d;
    end
  end
endmodule

// File: tb/tb_aes_blok_paketleyici.sv
// Bench for aes_blok_paketleyici: byte-queue reference model, pulse monitor,
// one task per scenario; a second instance covers zero-byte padding.
module tb_aes_blok_paketleyici;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   g_bayt = 8'h00;
  logic         g_bayt_gecerli = 1'b0;
  logic         g_bayt_son = 1'b0;
  logic         hazir = 1'b0;
  logic         g_bayt_hazir, g_gecerli, fifo_bos, fifo_dolu;
  logic [127:0] blok;
  logic [1:0]   seviye;
  logic         g_bayt_hazir0, g_gecerli0, fifo_bos0, fifo_dolu0;
  logic [127:0] blok0;
  logic [1:0]   seviye0;

  aes_blok_paketleyici #(.FIFO_DERINLIK(D), .DOLGU_MODU(1)) dut (
    .clk(clk), .rst(rst), .g_bayt(g_bayt), .g_bayt_gecerli(g_bayt_gecerli),
    .g_bayt_son(g_bayt_son), .g_bayt_hazir(g_bayt_hazir), .hazir(hazir),
    .blok(blok), .g_gecerli(g_gecerli), .fifo_bos(fifo_bos),
    .fifo_dolu(fifo_dolu), .seviye(seviye));

  aes_blok_paketleyici #(.FIFO_DERINLIK(D), .DOLGU_MODU(0)) dut0 (
    .clk(clk), .rst(rst), .g_bayt(g_bayt), .g_bayt_gecerli(g_bayt_gecerli),
    .g_bayt_son(g_bayt_son), .g_bayt_hazir(g_bayt_hazir0), .hazir(hazir),
    .blok(blok0), .g_gecerli(g_gecerli0), .fifo_bos(fifo_bos0),
    .fifo_dolu(fifo_dolu0), .seviye(seviye0));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int max_seviye = 0;

  logic [7:0]   cur[$];
  logic [127:0] exp1[$], exp0[$], obs1[$], obs0[$];
  int           obs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (g_gecerli) begin
      obs1.push_back(blok);
      obs_cyc.push_back(cyc);
      $display("issue cyc=%0d blok=%h", cyc, blok);
    end
    if (g_gecerli0) obs0.push_back(blok0);
    if (int'(seviye) > max_seviye) max_seviye = int'(seviye);
  end

  // Message-level model: collect bytes, close a block at 16 bytes or on son.
  task automatic model_accept(input logic [7:0] b, input logic son);
    logic [127:0] w1, w0;
    int n;
    cur.push_back(b);
    if (son || cur.size() == 16) begin
      n = cur.size();
      w1 = '0;
      w0 = '0;
      for (int i = 0; i < 16; i++) begin
        w1 = {w1[119:0], (i < n) ? cur[i] : 8'(16 - n)};
        w0 = {w0[119:0], (i < n) ? cur[i] : 8'h00};
      end
      exp1.push_back(w1);
      exp0.push_back(w0);
      cur.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic son, output int ec);
    int n;
    n = 0;
    @(negedge clk);
    g_bayt = b;
    g_bayt_son = son;
    g_bayt_gecerli = 1'b1;
    while (!g_bayt_hazir && n < 300) begin
      @(negedge clk);
      n++;
    end
    ec = -1;
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted after %0d cycles, required acceptance", b, n);
    end else begin
      @(posedge clk);
      model_accept(b, son);
      #1;
      ec = cyc;
    end
    g_bayt_gecerli = 1'b0;
    g_bayt_son = 1'b0;
  endtask

  task automatic bosalt(input string ad);
    int n;
    n = 0;
    while (obs1.size() < exp1.size() && n < 200) begin
      @(negedge clk); hazir = 1'b0;
      @(negedge clk); hazir = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    hazir = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s_drain: issued %0d blocks, required %0d", ad, obs1.size(), exp1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks += 7;
    if (blok !== 128'h0) begin errors++; $display("FAIL reset_blok: got %h want 0", blok); end
    if (g_gecerli !== 1'b0) begin errors++; $display("FAIL reset_g_gecerli: got %b want 0", g_gecerli); end
    if (fifo_bos !== 1'b1) begin errors++; $display("FAIL reset_fifo_bos: got %b want 1", fifo_bos); end
    if (fifo_dolu !== 1'b0) begin errors++; $display("FAIL reset_fifo_dolu: got %b want 0", fifo_dolu); end
    if (seviye !== 2'd0) begin errors++; $display("FAIL reset_seviye: got %0d want 0", seviye); end
    if (g_bayt_hazir !== 1'b1) begin errors++; $display("FAIL reset_g_bayt_hazir: got %b want 1", g_bayt_hazir); end
    if (blok0 !== 128'h0) begin errors++; $display("FAIL reset_blok0: got %h want 0", blok0); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_tam_blok();
    logic [127:0] msg;
    logic [127:0] beklenen;
    int ec;
    msg = 128'h71776572747975696f70617364666768;
    beklenen = 128'h71776572747975696f70617364666768;
    hazir = 1'b1;
    ec = 0;
    for (int i = 0; i < 16; i++) send_byte(msg[127-8*i -: 8], i == 15, ec);
    repeat (5) @(negedge clk);
    #2;
    checks += 4;
    if (obs1.size() != 1) begin
      errors++; $display("FAIL t1_pulse_count: got %0d want 1", obs1.size());
    end else begin
      if (obs1[0] !== beklenen) begin errors++; $display("FAIL t1_blok: got %h want %h", obs1[0], beklenen); end
      if (obs1[0] !== exp1[0]) begin errors++; $display("FAIL t1_model: got %h want %h", obs1[0], exp1[0]); end
      if (obs_cyc[0] != ec + 1) begin errors++; $display("FAIL t1_latency: pulse at cyc %0d want %0d", obs_cyc[0], ec + 1); end
    end
    hazir = 1'b0;
    repeat (3) @(negedge clk);
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete(); obs_cyc.delete();
  endtask

  task automatic test_dolgu();
    logic [127:0] b1, b0;
    int ec;
    b1 = 128'h0102030405060a0a0a0a0a0a0a0a0a0a;
    b0 = 128'h01020304050600000000000000000000;
    hazir = 1'b1;
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6, ec);
    repeat (5) @(negedge clk);
    #2;
    checks += 4;
    if (obs1.size() != 1 || obs0.size() != 1) begin
      errors++; $display("FAIL t2_count: got %0d/%0d want 1/1", obs1.size(), obs0.size());
    end else begin
      if (obs1[0] !== b1) begin errors++; $display("FAIL t2_pkcs7: got %h want %h", obs1[0], b1); end
      if (obs0[0] !== b0) begin errors++; $display("FAIL t2_sifir: got %h want %h", obs0[0], b0); end
      if (obs1[0] !== exp1[0] || obs0[0] !== exp0[0]) begin
        errors++; $display("FAIL t2_model: got %h/%h want %h/%h", obs1[0], obs0[0], exp1[0], exp0[0]);
      end
    end
    hazir = 1'b0;
    repeat (3) @(negedge clk);
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete(); obs_cyc.delete();
  endtask

  task automatic test_dolu();
    logic [7:0] b;
    int ec;
    hazir = 1'b0;
    for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b0, ec);
    b = 8'($urandom);
    @(negedge clk);
    g_bayt = b; g_bayt_son = 1'b0; g_bayt_gecerli = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks += 5;
    if (seviye !== 2'd2) begin errors++; $display("FAIL t3_seviye: got %0d want 2", seviye); end
    if (fifo_dolu !== 1'b1) begin errors++; $display("FAIL t3_dolu: got %b want 1", fifo_dolu); end
    if (g_bayt_hazir !== 1'b0) begin errors++; $display("FAIL t3_stall: got %b want 0", g_bayt_hazir); end
    if (fifo_bos !== 1'b0) begin errors++; $display("FAIL t3_bos: got %b want 0", fifo_bos); end
    if (obs1.size() != 0) begin errors++; $display("FAIL t3_early_issue: got %0d want 0", obs1.size()); end
    hazir = 1'b1;
    @(negedge clk);
    #2;
    checks += 3;
    if (g_gecerli !== 1'b1) begin errors++; $display("FAIL t3_issue: got %b want 1", g_gecerli); end
    if (g_bayt_hazir !== 1'b1) begin errors++; $display("FAIL t3_ready_back: got %b want 1", g_bayt_hazir); end
    if (seviye !== 2'd1) begin errors++; $display("FAIL t3_seviye_pop: got %0d want 1", seviye); end
    @(posedge clk);
    model_accept(b, 1'b0);
    #1;
    g_bayt_gecerli = 1'b0;
    checks++;
    if (obs1.size() < 1 || obs1[0] !== exp1[0]) begin
      errors++; $display("FAIL t3_first_block: got %h want %h", (obs1.size() > 0) ? obs1[0] : 128'h0, exp1[0]);
    end
    for (int i = 0; i < 15; i++) send_byte(8'($urandom), 1'b0, ec);
    bosalt("t3");
    checks++;
    if (obs1.size() != exp1.size()) begin errors++; $display("FAIL t3_count: got %0d want %0d", obs1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++;
      if (obs1[i] !== exp1[i]) begin errors++; $display("FAIL t3_order[%0d]: got %h want %h", i, obs1[i], exp1[i]); end
    end
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete(); obs_cyc.delete();
  endtask

  task automatic test_hazir_tutma();
    int ec;
    hazir = 1'b0;
    for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b0, ec);
    @(negedge clk); hazir = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (obs1.size() != 1) begin errors++; $display("FAIL t4_first_rise: got %0d pulses want 1", obs1.size()); end
    hazir = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (obs1.size() != 1) begin errors++; $display("FAIL t4_low: got %0d pulses want 1", obs1.size()); end
    hazir = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (obs1.size() != 2) begin errors++; $display("FAIL t4_second_rise: got %0d pulses want 2", obs1.size()); end
    hazir = 1'b0;
    repeat (3) @(negedge clk);
    hazir = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    checks++;
    if (obs1.size() != 2) begin errors++; $display("FAIL t4_empty_rise: got %0d pulses want 2", obs1.size()); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++;
      if (obs1[i] !== exp1[i]) begin errors++; $display("FAIL t4_order[%0d]: got %h want %h", i, obs1[i], exp1[i]); end
    end
    hazir = 1'b0;
    repeat (3) @(negedge clk);
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete(); obs_cyc.delete();
  endtask

  task automatic test_orta_reset();
    int ec;
    int n;
    hazir = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0, ec);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0, ec);
    @(negedge clk); hazir = 1'b1;
    n = 0;
    while (!g_gecerli && n < 20) begin @(negedge clk); n++; end
    #2;
    rst = 1'b0;
    #1;
    checks += 7;
    if (n >= 20) begin errors++; $display("FAIL t5_no_issue: waited %0d cycles, required a pulse", n); end
    if (g_gecerli !== 1'b0) begin errors++; $display("FAIL t5_pulse_drop: got %b want 0", g_gecerli); end
    if (blok !== 128'h0) begin errors++; $display("FAIL t5_blok: got %h want 0", blok); end
    if (fifo_bos !== 1'b1) begin errors++; $display("FAIL t5_bos: got %b want 1", fifo_bos); end
    if (fifo_dolu !== 1'b0) begin errors++; $display("FAIL t5_dolu: got %b want 0", fifo_dolu); end
    if (seviye !== 2'd0) begin errors++; $display("FAIL t5_seviye: got %0d want 0", seviye); end
    if (g_bayt_hazir !== 1'b1) begin errors++; $display("FAIL t5_hazir: got %b want 1", g_bayt_hazir); end
    checks++;
    if (obs1.size() != 1 || obs1[0] !== exp1[0]) begin
      errors++; $display("FAIL t5_pre_reset_block: got %0d blocks, required 1 matching %h", obs1.size(), exp1[0]);
    end
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete(); obs_cyc.delete(); cur.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0, ec);
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if (obs1.size() != 1 || exp1.size() != 1) begin
      errors++; $display("FAIL t5_post_count: got %0d blocks want 1", obs1.size());
    end else if (obs1[0] !== exp1[0]) begin
      errors++; $display("FAIL t5_clean_block: got %h want %h", obs1[0], exp1[0]);
    end
    hazir = 1'b0;
    repeat (3) @(negedge clk);
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete(); obs_cyc.delete();
  endtask

  task automatic test_back_to_back();
    logic tx_done;
    int nmsg;
    int ec;
    tx_done = 1'b0;
    max_seviye = 0;
    fork
      begin
        for (int m = 0; m < 5; m++) begin
          nmsg = (m < 3) ? 16 : int'($urandom_range(1, 15));
          for (int i = 0; i < nmsg; i++) send_byte(8'($urandom), i == nmsg - 1, ec);
        end
        tx_done = 1'b1;
      end
      begin
        for (int n = 0; n < 3000 && !(tx_done && obs1.size() == exp1.size()); n++) begin
          @(negedge clk);
          hazir = 1'($urandom_range(0, 1));
        end
      end
    join
    bosalt("t6");
    checks += 3;
    if (obs1.size() != exp1.size()) begin errors++; $display("FAIL t6_count: got %0d want %0d", obs1.size(), exp1.size()); end
    if (obs0.size() != exp0.size()) begin errors++; $display("FAIL t6_count0: got %0d want %0d", obs0.size(), exp0.size()); end
    if (max_seviye > D) begin errors++; $display("FAIL t6_seviye_max: got %0d want <= %0d", max_seviye, D); end
    for (int i = 0; i < exp1.size() && i < obs1.size(); i++) begin
      checks++;
      if (obs1[i] !== exp1[i]) begin errors++; $display("FAIL t6_block[%0d]: got %h want %h", i, obs1[i], exp1[i]); end
    end
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
      checks++;
      if (obs0[i] !== exp0[i]) begin errors++; $display("FAIL t6_block0[%0d]: got %h want %h", i, obs0[i], exp0[i]); end
    end
    obs1.delete(); obs0.delete(); exp1.delete(); exp0.delete(); obs_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_tam_blok();
    test_dolgu();
    test_dolu();
    test_hazir_tutma();
    test_orta_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
